// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle add/sub/mul/div sequencer with registered result, remainder and flag.
module calc_alu_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [16:0] c_o,
    output logic [15:0] rem_o,
    output logic        flag_o
);
    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d, w_q, w_d, rem_q, rem_d;
    logic [31:0] acc_q, acc_d, mc_q, mc_d, prod;
    logic [16:0] c_q, c_d, trial, diff;
    logic        flag_q, flag_d, ge;
    logic [15:0] rnext;
    // a_q is the multiplier (shifted right) in MUL and the dividend/quotient shift register in DIV
    assign prod   = acc_q + (a_q[0] ? mc_q : 32'd0);
    assign trial  = {w_q, a_q[15]};
    assign ge     = trial >= {1'b0, b_q};
    assign diff   = trial - {1'b0, b_q};
    assign rnext  = ge ? diff[15:0] : trial[15:0];
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign c_o    = c_q;
    assign rem_o  = rem_q;
    assign flag_o = flag_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        c_d     = c_q;
        rem_d   = rem_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: if (start_i) begin
                a_d     = a_i;
                b_d     = b_i;
                op_d    = op_i;
                cnt_d   = 4'd0;
                acc_d   = 32'd0;
                mc_d    = {16'd0, b_i};
                w_d     = 16'd0;
                state_d = op_i[1] ? (op_i[0] ? DIV : MUL) : ADDSUB;
            end
            ADDSUB: begin
                c_d     = op_q[0] ? {1'b0, a_q} - {1'b0, b_q} : {1'b0, a_q} + {1'b0, b_q};
                flag_d  = op_q[0] & (a_q < b_q);
                rem_d   = 16'd0;
                state_d = DONE;
            end
            MUL: begin
                acc_d = prod;
                mc_d  = mc_q << 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    c_d     = prod[16:0];
                    flag_d  = |prod[31:17];
                    rem_d   = 16'd0;
                    state_d = DONE;
                end
            end
            DIV: if (b_q == 16'd0) begin
                c_d     = 17'd0;
                rem_d   = 16'd0;
                flag_d  = 1'b1;
                state_d = DONE;
            end else begin
                w_d   = rnext;
                a_d   = {a_q[14:0], ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    c_d     = {1'b0, a_q[14:0], ge};
                    rem_d   = rnext;
                    flag_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            w_q     <= 16'd0;
            acc_q   <= 32'd0;
            mc_q    <= 32'd0;
            c_q     <= 17'd0;
            rem_q   <= 16'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer: directed-vector bench for calc_alu_sequencer.
module tb_calc_alu_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a = 16'd0, b = 16'd0;
    logic        busy, done, flag;
    logic [16:0] c;
    logic [15:0] rem;
    int          tests = 0, fails = 0;

    calc_alu_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .c_o(c), .rem_o(rem), .flag_o(flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy duration, results and return to idle.
    // With glitch set, a conflicting Start and new operands are driven mid-operation.
    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input int exp_lat, input logic [16:0] ec, input logic [15:0] er, input logic ef,
                       input bit glitch);
        int lat, bsy;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bsy = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (glitch && lat == 5) begin
                start = 1'b1; op = 2'b00; a = 16'h7777; b = 16'h1111;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
            if (busy) bsy++;
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, bsy, exp_lat);
        chk({tag, " C"}, {15'd0, c}, {15'd0, ec});
        chk({tag, " Rem"}, {16'd0, rem}, {16'd0, er});
        chk({tag, " Flag"}, {31'd0, flag}, {31'd0, ef});
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int dcnt;
        #2;
        chk("reset outputs", {busy, done, flag, c, rem}, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("add",      2'b00, 16'hFFFF, 16'h0001, 2,  17'h10000, 16'h0000, 1'b0, 1'b0);
        run("sub_neg",  2'b01, 16'h0003, 16'h0005, 2,  17'h1FFFE, 16'h0000, 1'b1, 1'b0);
        run("sub_pos",  2'b01, 16'h0005, 16'h0003, 2,  17'h00002, 16'h0000, 1'b0, 1'b0);
        run("mul",      2'b10, 16'h00FF, 16'h0102, 17, 17'h100FE, 16'h0000, 1'b0, 1'b0);
        run("mul_ovf",  2'b10, 16'h0400, 16'h0080, 17, 17'h00000, 16'h0000, 1'b1, 1'b0);
        run("mul_b2b",  2'b10, 16'hFFFF, 16'hFFFF, 17, 17'h00001, 16'h0000, 1'b1, 1'b0);
        run("div",      2'b11, 16'h0064, 16'h0007, 17, 17'h0000E, 16'h0002, 1'b0, 1'b0);
        run("div_zero", 2'b11, 16'h1234, 16'h0000, 2,  17'h00000, 16'h0000, 1'b1, 1'b0);
        run("mul_glitch", 2'b10, 16'h0003, 16'h0005, 17, 17'h0000F, 16'h0000, 1'b0, 1'b1);
        run("div2",     2'b11, 16'hFFFF, 16'h0010, 17, 17'h00FFF, 16'h000F, 1'b0, 1'b0);
        // Abort a divide partway through with an asynchronous reset.
        @(negedge clk);
        op = 2'b11; a = 16'h0064; b = 16'h0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort outputs", {busy, done, flag, c, rem}, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort no done", dcnt, 0);
        run("add_after", 2'b00, 16'h0001, 16'h0001, 2, 17'h00002, 16'h0000, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calc_alu_sequencer.md
# calc_alu_sequencer

Multi-cycle arithmetic sequencer for the simple calculator. It latches two 16-bit operands and an operation code on a start pulse and runs the selected operation. Add and subtract take one cycle. Multiply uses 16 iterations of shift-add; divide uses 16 iterations of restoring division. It then presents a 17-bit result, a remainder and an error/overflow flag with a one-cycle Done pulse. It sits between the calculator control FSM (which issues Start from its Add/Sub/Mul/Div states) and the result consumers (SSD and VGA output).

## Interface
- No parameters; widths fixed (16-bit operands, 17-bit result).
- Clk  in  1  system clock (board clock, 100 MHz); all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset; clears all state and outputs.
- Start  in  1  single-cycle request pulse (debounced SCEN style); sampled only in IDLE.
- Op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div; latched with Start.
- A  in  16  first operand (dividend / minuend); latched with Start.
- B  in  16  second operand (divisor / subtrahend); latched with Start.
- Busy  out  1  high from the edge accepting Start through the DONE cycle.
- Done  out  1  one-cycle pulse; C, Rem and Flag are valid and held from this cycle on.
- C  out  17  result.
- Rem  out  16  division remainder; 0 for other ops.
- Flag  out  1  error/overflow indication; meaning depends on Op.

## Operation
- States: IDLE, ADDSUB, MUL, DIV, DONE. Reset enters IDLE.
- IDLE + Start=1: latch A, B, Op into internal registers. Go to ADDSUB (Op 0x), MUL (10) or DIV (11). Clear the 4-bit iteration counter.
- IDLE + Start=0: stay in IDLE. Outputs hold the previous result.
- ADDSUB (1 cycle), add: C = {1'b0,A} + {1'b0,B}; Flag = 0.
- ADDSUB, sub: C = {1'b0,A} - {1'b0,B} as 17-bit two's complement; Flag = 1 when A < B.
- ADDSUB exits to DONE in both cases.
- MUL: 32-bit accumulator; multiplier shifted right LSB-first, multiplicand shifted left; one iteration per cycle, 16 cycles (counter 0..15).
- MUL at counter 15: C = product[16:0]; Flag = |product[31:17]; exit to DONE.
- DIV with latched B == 0: no iterations. C = 0, Rem = 0, Flag = 1; exit to DONE after one cycle.
- DIV otherwise: restoring division, one quotient bit per cycle MSB-first, 16 cycles.
- DIV at counter 15: C = {1'b0,quotient}; Rem = remainder; Flag = 0; exit to DONE.
- DONE: Done = 1 for exactly one cycle, then IDLE.
- C, Rem, Flag update only on the edge entering DONE. They hold until the next such edge.
- Start while Busy=1, including the DONE cycle: ignored, not queued.
- A, B, Op changes after acceptance: no effect on the operation in progress.
- Rem is written 0 on add, sub and mul completions.

## Timing
- Reset values: Busy=0, Done=0, C=17'h00000, Rem=16'h0000, Flag=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately (asynchronous) and forces the reset values above. No Done is produced for the aborted operation.
- Start sampled at edge k. Busy goes high after edge k.
- Add/sub: results registered at edge k+1. Done high between edges k+1 and k+2.
- Divide by zero: same timing as add/sub.
- Mul and nonzero div: results registered at edge k+16. Done high between edges k+16 and k+17.
- Busy falls after edge k+2 (add/sub, div-by-zero) or k+17 (mul/div).
- Earliest next accepted Start is at the edge where Busy has just fallen, i.e. the edge after Done.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Add: reset, Start with Op=00, A=FFFF, B=0001 -> C=10000, Flag=0, Rem=0, Done exactly 2 edges after Start.
- Sub: Op=01, A=0003, B=0005 -> C=1FFFE, Flag=1.
- Sub: Op=01, A=0005, B=0003 -> C=00002, Flag=0.
- Mul without overflow: Op=10, A=00FF, B=0102 -> C=100FE, Flag=0, Done 17 edges after Start; Busy high for 17 cycles.
- Mul with overflow: Op=10, A=0400, B=0080 -> C=00000, Flag=1.
- Mul back-to-back: second Start issued on the edge after Done, Op=10, A=FFFF, B=FFFF -> C=00001, Flag=1.
- Divide: Op=11, A=0064, B=0007 -> C=0000E, Rem=0002, Flag=0, Done after 17 edges.
- Divide by zero: Op=11, A=1234, B=0000 -> C=0, Rem=0, Flag=1, Done after 2 edges.
- Robustness: Start mid-multiply with different operands -> ignored; original result delivered.
- Reset_n low at iteration 8 of a divide -> all outputs 0 immediately, no Done pulse.
- After reset: a fresh add of 0001+0001 -> C=00002.
